// File: rtl/irq_controller_pkg.sv
// Shared definitions for irq_controller: register map offsets, FSM state type
// and the lowest-index priority helper.
package irq_controller_pkg;

   localparam logic [4:0] REG_PENDING = 5'h00;
   localparam logic [4:0] REG_ENABLE  = 5'h04;
   localparam logic [4:0] REG_ACTIVE  = 5'h08;
   localparam logic [4:0] REG_ACK     = 5'h0C;
   localparam logic [4:0] REG_COUNT   = 5'h10;

   localparam int ACTIVE_VALID_BIT = 31;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLAIM = 1'b1
   } state_e;

   // Index of the lowest set bit; returns 0 when no bit is set.
   function automatic logic [4:0] lowest_set(input logic [31:0] vec);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_controller_edge_sync.sv
// Per-source two-flop synchroniser followed by a registered rising-edge detector.
// The rise pulse is one clock wide and appears three edges after the first high sample.
module irq_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic rise_q,  rise_d;

   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      rise_d  = sync2_q & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         rise_q  <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller for the PicoRV32 irq input on the mem_* bus.
// Optional claim counter is built only when IRQ_CONTROLLER_COUNTER_EN is defined.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int          NSRC      = 8,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NSRC-1:0]   src_irq,
   input  logic              mem_valid,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wstrb,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic              cpu_irq,
   output logic [4:0]        irq_id,
   output logic [CNT_W-1:0]  irq_counter,
   output state_e            dbg_state
);

   // Bus handshake: the master holds mem_valid (and addr/data/strobes) until it
   // sees mem_ready; an in-window request is answered by exactly one mem_ready
   // pulse the cycle after it is first seen, and write side effects land on that
   // same edge. The ~ready_q term stops a held mem_valid from being served twice.
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        in_win, access, wr_en, rd_en;
   logic [4:0]  offset;
   logic        wr_pending, wr_enable, wr_ack, wr_count;

   logic [NSRC-1:0] rise_vec;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] enable_q,  enable_d;
   logic [NSRC-1:0] req;
   logic [NSRC-1:0] clr_mask;
   logic [NSRC-1:0] claim_mask;

   state_e      state_q, state_d;
   logic [4:0]  id_q, id_d;
   logic [4:0]  id_sel;
   logic        holdoff_q, holdoff_d;
   logic        claim_go;
   logic        irq_out;
   logic [31:0] count_rd;

   logic unused_bits;
   assign unused_bits = ^{mem_addr[1:0], mem_wdata};

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      irq_edge_sync u_sync (
         .clk      (clk),
         .reset    (reset),
         .async_in (src_irq[i]),
         .rise     (rise_vec[i])
      );
   end

   always_comb begin
      in_win     = (mem_addr[31:5] == BASE_ADDR[31:5]);
      access     = mem_valid && in_win && !ready_q;
      wr_en      = access && (mem_wstrb != 4'b0000);
      rd_en      = access && (mem_wstrb == 4'b0000);
      offset     = {mem_addr[4:2], 2'b00};
      wr_pending = wr_en && (offset == REG_PENDING);
      wr_enable  = wr_en && (offset == REG_ENABLE);
      wr_ack     = wr_en && (offset == REG_ACK);
      wr_count   = wr_en && (offset == REG_COUNT);
   end

   // FSM process 1: state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         id_q      <= '0;
         holdoff_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         holdoff_q <= holdoff_d;
      end
   end

   // FSM process 2: next state. A released claim forces one extra settle cycle
   // in IDLE so the next claim rises two edges after the acknowledging write.
   always_comb begin
      req       = pending_q & enable_q;
      id_sel    = lowest_set(32'(req));
      state_d   = state_q;
      claim_go  = 1'b0;
      holdoff_d = 1'b0;
      id_d      = id_q;
      case (state_q)
         IDLE: begin
            if ((req != '0) && !holdoff_q) begin
               state_d  = CLAIM;
               claim_go = 1'b1;
               id_d     = id_sel;
            end
         end
         CLAIM: begin
            if (wr_ack) begin
               state_d   = IDLE;
               holdoff_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM process 3: outputs.
   always_comb begin
      irq_out   = (state_q == CLAIM);
      dbg_state = state_q;
   end

   // New edges are OR-ed in after clearing, so a set beats a same-cycle clear.
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         claim_mask[i] = claim_go && (id_sel == 5'(i));
      end
      clr_mask  = claim_mask | (wr_pending ? mem_wdata[NSRC-1:0] : '0);
      pending_d = (pending_q & ~clr_mask) | rise_vec;
      enable_d  = wr_enable ? mem_wdata[NSRC-1:0] : enable_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         enable_q  <= '0;
      end else begin
         pending_q <= pending_d;
         enable_q  <= enable_d;
      end
   end

`ifdef IRQ_CONTROLLER_COUNTER_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_count) begin
         cnt_d = claim_go ? CNT_W'(1) : '0;
      end else if (claim_go && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign irq_counter = cnt_q;
   assign count_rd    = 32'(cnt_q);
`else
   logic unused_count;
   assign unused_count = wr_count;
   assign irq_counter  = '0;
   assign count_rd     = '0;
`endif

   always_comb begin
      ready_d = access;
      rdata_d = '0;
      if (rd_en) begin
         case (offset)
            REG_PENDING: rdata_d = 32'(pending_q);
            REG_ENABLE:  rdata_d = 32'(enable_q);
            REG_ACTIVE: begin
               rdata_d[ACTIVE_VALID_BIT] = irq_out;
               rdata_d[4:0]              = id_q;
            end
            REG_COUNT:   rdata_d = count_rd;
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end
   end

   assign mem_ready = ready_q;
   assign mem_rdata = rdata_q;
   assign cpu_irq   = irq_out;
   assign irq_id    = id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller with a read-data scoreboard.
// Expected COUNT values follow IRQ_CONTROLLER_COUNTER_EN when it is defined.
`timescale 1ns/1ps
module tb_irq_controller;
   import irq_controller_pkg::*;

   localparam int          NSRC  = 8;
   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam int          CNT_W = 4;

`ifdef IRQ_CONTROLLER_COUNTER_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [NSRC-1:0]   src_irq;
   logic              mem_valid;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_ready;
   logic [31:0]       mem_rdata;
   logic              cpu_irq;
   logic [4:0]        irq_id;
   logic [CNT_W-1:0]  irq_counter;
   state_e            dbg_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   irq_controller #(.NSRC(NSRC), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .src_irq     (src_irq),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .cpu_irq     (cpu_irq),
      .irq_id      (irq_id),
      .irq_counter (irq_counter),
      .dbg_state   (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver tasks: called at a negedge, drive immediately, return at the
   // negedge on which mem_ready is seen
   task automatic bus_write(input logic [4:0] off, input logic [31:0] data, input string tag);
      int n;
      mem_valid = 1'b1;
      mem_addr  = BASE + 32'(off);
      mem_wdata = data;
      mem_wstrb = 4'hF;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_ready && n < 20);
      check({tag, "_wr_ready"}, 32'(mem_ready), 32'd1);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic bus_read(input logic [4:0] off, input logic [31:0] exp, input string tag);
      int n;
      exp_q.push_back(exp);
      mem_valid = 1'b1;
      mem_addr  = BASE + 32'(off);
      mem_wstrb = 4'h0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_ready && n < 20);
      mem_valid = 1'b0;
      if (mem_ready) check(tag, mem_rdata, exp_q.pop_front());
      else           check({tag, "_timeout"}, 32'(mem_ready), 32'd1);
      if (exp_q.size() != 0 && !mem_ready) void'(exp_q.pop_front());
   endtask

   task automatic pulse_src(input logic [NSRC-1:0] mask);
      src_irq = src_irq | mask;
      repeat (3) @(negedge clk);
      src_irq = src_irq & ~mask;
   endtask

   task automatic wait_irq(input string tag);
      int n;
      n = 0;
      while (!cpu_irq && n < 30) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_irq_wait"}, 32'(cpu_irq), 32'd1);
   endtask

   initial begin
      logic seen_ready;
      reset     = 1'b1;
      src_irq   = '0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      repeat (3) @(negedge clk);
      check("rst_cpu_irq", 32'(cpu_irq), 32'd0);
      check("rst_irq_id", 32'(irq_id), 32'd0);
      check("rst_ready", 32'(mem_ready), 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      check("rst_counter", 32'(irq_counter), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         bus_read(5'(i * 4), 32'd0, $sformatf("rst_read_%0d", i));
      end
      check("idle_rdata_zero", mem_rdata, 32'd0);
      check("rst_cpu_irq_after_reads", 32'(cpu_irq), 32'd0);

      // single source: edge-to-irq latency, ACTIVE, ACK, COUNT
      bus_write(REG_ENABLE, 32'h05, "en05");
      bus_read(REG_ENABLE, 32'h05, "en_readback");
      src_irq[2] = 1'b1;
      repeat (3) @(negedge clk);
      src_irq[2] = 1'b0;
      @(negedge clk);
      check("lat_k3_low", 32'(cpu_irq), 32'd0);
      @(negedge clk);
      check("lat_k4_high", 32'(cpu_irq), 32'd1);
      check("id_src2", 32'(irq_id), 32'd2);
      bus_read(REG_ACTIVE, 32'h8000_0002, "active_src2");
      bus_read(REG_PENDING, 32'h0, "pending_cleared_by_claim");
      bus_write(REG_ACK, 32'h0, "ack1");
      check("ack1_irq_low", 32'(cpu_irq), 32'd0);
      bus_read(REG_COUNT, CNT_ON ? 32'd1 : 32'd0, "count_after_one");

      // two sources together: lowest index first, next claim at a+2
      pulse_src(8'h05);
      wait_irq("pair");
      check("pair_first_id", 32'(irq_id), 32'd0);
      bus_read(REG_ACTIVE, 32'h8000_0000, "active_src0");
      bus_write(REG_ACK, 32'h0, "ack_pair1");
      check("pair_a_low", 32'(cpu_irq), 32'd0);
      @(negedge clk);
      check("pair_a1_low", 32'(cpu_irq), 32'd0);
      @(negedge clk);
      check("pair_a2_high", 32'(cpu_irq), 32'd1);
      check("pair_second_id", 32'(irq_id), 32'd2);
      bus_write(REG_ACK, 32'h0, "ack_pair2");
      bus_write(REG_ACK, 32'h0, "ack_in_idle");
      check("ack_idle_no_irq", 32'(cpu_irq), 32'd0);
      bus_read(REG_ACK, 32'h0, "ack_reads_zero");

      // disabled source: pending only, W1C, set beats clear
      bus_write(REG_ENABLE, 32'h0, "en00");
      pulse_src(8'h02);
      repeat (4) @(negedge clk);
      check("disabled_no_irq", 32'(cpu_irq), 32'd0);
      bus_read(REG_PENDING, 32'h02, "pending_disabled");
      bus_write(REG_PENDING, 32'h02, "w1c");
      bus_read(REG_PENDING, 32'h0, "pending_after_w1c");
      src_irq[1] = 1'b1;
      repeat (3) @(negedge clk);
      bus_write(REG_PENDING, 32'h02, "w1c_race");
      src_irq[1] = 1'b0;
      bus_read(REG_PENDING, 32'h02, "set_wins_over_clear");
      bus_write(REG_PENDING, 32'hFFFF_FFFF, "w1c_all");
      bus_read(REG_PENDING, 32'h0, "pending_all_cleared");
      bus_write(5'h14, 32'hFFFF_FFFF, "reserved_wr");
      bus_read(5'h14, 32'h0, "reserved_rd");

      // reset mid-claim, then out-of-window access
      pulse_src(8'h01);
      bus_write(REG_ENABLE, 32'h02, "en02");
      pulse_src(8'h02);
      wait_irq("pre_reset");
      reset = 1'b1;
      @(negedge clk);
      check("reset_drops_irq", 32'(cpu_irq), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      bus_read(REG_PENDING, 32'h0, "pending_after_reset");
      bus_read(REG_ENABLE, 32'h0, "enable_after_reset");
      check("counter_after_reset", 32'(irq_counter), 32'd0);
      seen_ready = 1'b0;
      mem_valid = 1'b1;
      mem_addr  = BASE + 32'h40;
      mem_wstrb = 4'h0;
      repeat (8) begin
         @(negedge clk);
         seen_ready = seen_ready | mem_ready;
      end
      mem_valid = 1'b0;
      check("out_of_window_no_ready", 32'(seen_ready), 32'd0);

      // counter saturation over 17 claims
      bus_write(REG_ENABLE, 32'h01, "en01");
      for (int c = 0; c < 17; c++) begin
         pulse_src(8'h01);
         wait_irq($sformatf("claim_%0d", c));
         check($sformatf("claim_%0d_id", c), 32'(irq_id), 32'd0);
         bus_write(REG_ACK, 32'h0, "ack_loop");
         repeat (2) @(negedge clk);
      end
      bus_read(REG_COUNT, CNT_ON ? 32'd15 : 32'd0, "count_saturated");
      check("counter_port_saturated", 32'(irq_counter), CNT_ON ? 32'd15 : 32'd0);
      bus_write(REG_COUNT, 32'h0, "count_clear");
      bus_read(REG_COUNT, 32'h0, "count_after_clear");
      check("counter_port_cleared", 32'(irq_counter), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
